matvec_engine: RTL and testbench
================================

MATVEC_ENGINE -- requirements
Module: matvec_engine

Interface
REQ-001 Parameter NROW, default 16: output vector length / matrix rows.
REQ-002 Parameter NCOL, default 16: input vector length / matrix columns.
REQ-003 Parameter QN, default 6: integer bits. Parameter QM, default 11: fraction bits. BW = QN+QM+1, signed two's complement.
REQ-004 Parameter N_MAC, default 8: parallel MAC lanes; NROW SHALL be a multiple of N_MAC; P = NROW/N_MAC passes.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  request one matrix-vector product; sampled only in IDLE.
REQ-008 weightRow  in  NROW*BW  matrix column colAddress; row r at bits [r*BW +: BW]; valid in the same cycle as colAddress.
REQ-009 inputVector  in  BW  vector element colAddress; valid in the same cycle as colAddress.
REQ-010 colAddress  out  clog2(NCOL)  registered column read address.
REQ-011 busy  out  1  high in CALC and DONE.
REQ-012 dataReady  out  1  registered one-cycle pulse; outputVector valid from this cycle on.
REQ-013 outputVector  out  NROW*BW  registered result; row r at [r*BW +: BW]; held until the next dataReady.

Function
REQ-014 FSM states IDLE, CALC, DONE; IDLE->CALC on start, CALC->DONE after last accumulate, DONE->IDLE unconditionally.
REQ-015 On IDLE->CALC: colAddress=0, rowMux=0, all NROW accumulators cleared to 0.
REQ-016 Each CALC cycle, lane i SHALL add sext(weightRow[row]) * sext(inputVector) to acc[row], row = i*P+rowMux, full precision, no intermediate shift.
REQ-017 Accumulator width ACC_BW = 2*BW + clog2(NCOL); no overflow is possible inside the accumulator.
REQ-018 colAddress increments each CALC cycle and wraps NCOL-1 -> 0; rowMux increments on that wrap.
REQ-019 Last accumulate: colAddress==NCOL-1 and rowMux==P-1; CALC lasts exactly NCOL*P cycles.
REQ-020 In DONE: outputVector[r] <= acc[r] >>> QM (arithmetic, floor) narrowed to BW per REQ-026, for all r simultaneously; dataReady <= 1.
REQ-021 Latency: dataReady high NCOL*P+2 cycles after the edge sampling start.
REQ-022 start while busy is ignored, no queuing; start held high through DONE SHALL begin a new run in the cycle after DONE.
REQ-023 colAddress held at 0 in IDLE; weightRow/inputVector ignored outside CALC.

Reset
REQ-024 reset SHALL force state=IDLE, colAddress=0, rowMux=0, busy=0, dataReady=0, outputVector=0, accumulators=0, with priority over start.
REQ-025 reset mid-run SHALL abort without any dataReady pulse; the next run starts clean.

Configuration
REQ-026 With MATVEC_SAT_EN defined, shifted results outside [-2^(BW-1), 2^(BW-1)-1] SHALL clamp to those bounds; without it, the low BW bits are kept (wrap).

Structure
REQ-027 Package matvec_pkg SHALL hold the state enum, BW/ACC_BW derivation functions and a clog2 function.
REQ-028 Sub-module mac_lane holds one lane: multiplier, lane accumulators (P entries) and the narrow/saturate step; matvec_engine instantiates N_MAC lanes plus the FSM.

Verification (NROW=4, NCOL=4, N_MAC=2, QN=6, QM=11; 1.0=2048)
REQ-029 Identity matrix, x=[1.0,2.0,-0.5,3.0] -> outputVector=[2048,4096,-1024,6144], dataReady in the 10th cycle after the start edge (NCOL*P+2), one cycle wide.
REQ-030 All weights 31.0, all x 31.0 -> with MATVEC_SAT_EN every row = 131071; without it every row = low 18 bits of (3844*2048).
REQ-031 All weights -1.0, all x 0.5 -> every row = -4096; confirms floor shift and sign extension.
REQ-032 Pulse start at CALC cycles 2 and 5 -> single dataReady, result unchanged; start held high -> successive runs 10 cycles apart, accumulators cleared each run.
REQ-033 reset during CALC cycle 3 -> next cycle state IDLE, colAddress=0, outputVector=0, no dataReady; a following run gives correct results.

Source files
------------

// File: rtl/matvec_pkg.sv
// Shared types and width helpers for the matrix-vector engine.
// Optional build macro: MATVEC_SAT_EN (clamp instead of wrap when narrowing).
package matvec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2; 0 for a value of 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Address width that never collapses to zero bits.
  function automatic int addr_bw(input int depth);
    return (clog2(depth) > 0) ? clog2(depth) : 1;
  endfunction

  // Fixed-point word width: sign + integer + fraction.
  function automatic int calc_bw(input int qn, input int qm);
    return qn + qm + 1;
  endfunction

  // Full-precision product plus enough headroom for ncol additions.
  function automatic int calc_acc_bw(input int bw, input int ncol);
    return 2 * bw + clog2(ncol);
  endfunction

endpackage

// File: rtl/matvec_engine_mac_lane.sv
// One MAC lane: selects one of its P weights, multiplies by the shared
// vector element, accumulates into the selected row accumulator and
// presents all P accumulators shifted back to Q format and narrowed.
// Optional build macro: MATVEC_SAT_EN (clamp on narrowing, else wrap).
module mac_lane
  import matvec_pkg::*;
#(
  parameter int P      = 2,
  parameter int BW     = 18,
  parameter int ACC_BW = 38,
  parameter int QM     = 11,
  parameter int PW     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 acc_en,
  input  logic [PW-1:0]        row_sel,
  input  logic [P*BW-1:0]      weights,
  input  logic signed [BW-1:0] x,
  output logic [P*BW-1:0]      result
);

  logic signed [BW-1:0]     w_sel;
  logic signed [2*BW-1:0]   prod;
  logic signed [ACC_BW-1:0] prod_ext;
  logic signed [ACC_BW-1:0] acc [P];

  assign w_sel    = weights[row_sel*BW +: BW];
  assign prod     = w_sel * x;
  assign prod_ext = ACC_BW'(prod);

  // Row accumulators: cleared at run start, one row updated per enabled cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int j = 0; j < P; j++) acc[j] <= '0;
    end else if (acc_en) begin
      acc[row_sel] <= acc[row_sel] + prod_ext;
    end
  end

  for (genvar j = 0; j < P; j++) begin : g_narrow
`ifdef MATVEC_SAT_EN
    localparam int MAX_I = (1 << (BW - 1)) - 1;
    localparam int MIN_I = -(1 << (BW - 1));
    localparam logic signed [ACC_BW-1:0] MAX_ACC = ACC_BW'(MAX_I);
    localparam logic signed [ACC_BW-1:0] MIN_ACC = ACC_BW'(MIN_I);
    logic signed [ACC_BW-1:0] shifted;
    assign shifted = acc[j] >>> QM;
    assign result[j*BW +: BW] = (shifted > MAX_ACC) ? BW'(MAX_I) :
                                (shifted < MIN_ACC) ? BW'(MIN_I) :
                                shifted[BW-1:0];
`else
    // Floor shift, keep the low BW bits (two's complement wrap).
    assign result[j*BW +: BW] = BW'(acc[j] >>> QM);
`endif
  end

endmodule

// File: rtl/matvec_engine.sv
// Matrix-vector product engine: streams one matrix column per cycle,
// N_MAC lanes each own P = NROW/N_MAC rows and walk them pass by pass.
// Optional build macro: MATVEC_SAT_EN (saturating narrow of results).
//
// state | meaning
// IDLE  | waiting for start, colAddress held at 0
// CALC  | one accumulate per cycle, NCOL*P cycles
// DONE  | latch narrowed results, pulse dataReady
module matvec_engine
  import matvec_pkg::*;
#(
  parameter int NROW  = 16,
  parameter int NCOL  = 16,
  parameter int QN    = 6,
  parameter int QM    = 11,
  parameter int N_MAC = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [NROW*calc_bw(QN, QM)-1:0]      weightRow,
  input  logic [calc_bw(QN, QM)-1:0]           inputVector,
  output logic [addr_bw(NCOL)-1:0]             colAddress,
  output logic                                 busy,
  output logic                                 dataReady,
  output logic [NROW*calc_bw(QN, QM)-1:0]      outputVector
);

  localparam int BW     = calc_bw(QN, QM);
  localparam int ACC_BW = calc_acc_bw(BW, NCOL);
  localparam int P      = NROW / N_MAC;
  localparam int AW     = addr_bw(NCOL);
  localparam int PW     = addr_bw(P);

  if (NROW % N_MAC != 0) begin : g_bad_cfg
    $error("matvec_engine: NROW must be a multiple of N_MAC");
  end

  state_t            state, state_nxt;
  logic [PW-1:0]     row_mux;
  logic              col_wrap;
  logic              last_acc;
  logic              run_start;
  logic [NROW*BW-1:0] lane_result;

  assign col_wrap  = (colAddress == AW'(NCOL - 1));
  assign last_acc  = (state == CALC) && col_wrap && (row_mux == PW'(P - 1));
  assign run_start = (state == IDLE) && start;
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_acc) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Column address and pass counter: only advance in CALC, else parked at 0.
  always_ff @(posedge clk) begin
    if (reset || state != CALC) begin
      colAddress <= '0;
      row_mux    <= '0;
    end else begin
      colAddress <= col_wrap ? '0 : colAddress + AW'(1);
      if (col_wrap) row_mux <= (row_mux == PW'(P - 1)) ? '0 : row_mux + PW'(1);
    end
  end

  // Result register and completion pulse, loaded together in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      outputVector <= '0;
      dataReady    <= 1'b0;
    end else begin
      dataReady <= (state == DONE);
      if (state == DONE) outputVector <= lane_result;
    end
  end

  // Lane i owns rows i*P .. i*P+P-1, which are contiguous in the packed buses.
  for (genvar i = 0; i < N_MAC; i++) begin : g_lane
    mac_lane #(
      .P      (P),
      .BW     (BW),
      .ACC_BW (ACC_BW),
      .QM     (QM),
      .PW     (PW)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .clear   (run_start),
      .acc_en  (state == CALC),
      .row_sel (row_mux),
      .weights (weightRow[i*P*BW +: P*BW]),
      .x       (inputVector),
      .result  (lane_result[i*P*BW +: P*BW])
    );
  end

endmodule

// File: tb/tb_matvec_engine.sv
// Scoreboard bench for matvec_engine (4x4, two lanes, Q6.11).
// Honours MATVEC_SAT_EN the same way as the design.
module tb_matvec_engine;

  localparam int NROW  = 4;
  localparam int NCOL  = 4;
  localparam int N_MAC = 2;
  localparam int QN    = 6;
  localparam int QM    = 11;
  localparam int BW    = QN + QM + 1;
  localparam int P     = NROW / N_MAC;
  localparam int AW    = 2;
  localparam int LAT   = NCOL * P + 1;   // edges after the start edge until dataReady is seen
  localparam int ONE   = 2048;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [NROW*BW-1:0] weight_row;
  logic [BW-1:0]      input_vector;
  logic [AW-1:0]      col_address;
  logic               busy;
  logic               data_ready;
  logic [NROW*BW-1:0] output_vector;

  int w_mem [NROW][NCOL];
  int x_mem [NCOL];

  logic [NROW*BW-1:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;
  int dr_count = 0;
  int exp_dr = 0;
  int cyc = 0;
  int last_stamp = 0;
  int prev_stamp = 0;
  logic prev_dr = 1'b0;

  matvec_engine #(
    .NROW  (NROW),
    .NCOL  (NCOL),
    .QN    (QN),
    .QM    (QM),
    .N_MAC (N_MAC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .weightRow    (weight_row),
    .inputVector  (input_vector),
    .colAddress   (col_address),
    .busy         (busy),
    .dataReady    (data_ready),
    .outputVector (output_vector)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Matrix/vector memory answering the registered column address.
  always_comb begin
    weight_row   = '0;
    input_vector = BW'(x_mem[col_address]);
    for (int r = 0; r < NROW; r++) weight_row[r*BW +: BW] = BW'(w_mem[r][col_address]);
  end

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: full-precision dot product, floor shift, then narrow.
  function automatic logic [NROW*BW-1:0] model();
    logic [NROW*BW-1:0] res;
    longint acc, sh;
    res = '0;
    for (int r = 0; r < NROW; r++) begin
      acc = 0;
      for (int c = 0; c < NCOL; c++) acc += longint'(w_mem[r][c]) * longint'(x_mem[c]);
      sh = acc >>> QM;
`ifdef MATVEC_SAT_EN
      if (sh > longint'((1 << (BW - 1)) - 1)) sh = longint'((1 << (BW - 1)) - 1);
      else if (sh < -longint'(1 << (BW - 1))) sh = -longint'(1 << (BW - 1));
`endif
      res[r*BW +: BW] = sh[BW-1:0];
    end
    return res;
  endfunction

  // Output monitor: every dataReady pops one expectation.
  always @(negedge clk) begin
    logic [NROW*BW-1:0] exp_v;
    if (!reset && data_ready) begin
      dr_count++;
      prev_stamp = last_stamp;
      last_stamp = cyc;
      check("dr_single_cycle", prev_dr, 0);
      check("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        for (int r = 0; r < NROW; r++)
          check($sformatf("row%0d", r), $signed(output_vector[r*BW +: BW]),
                $signed(exp_v[r*BW +: BW]));
      end
    end
    prev_dr = data_ready;
  end

  task automatic fill_const(input int w, input int x);
    for (int r = 0; r < NROW; r++)
      for (int c = 0; c < NCOL; c++) w_mem[r][c] = w;
    for (int c = 0; c < NCOL; c++) x_mem[c] = x;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < NROW; r++)
      for (int c = 0; c < NCOL; c++) w_mem[r][c] = int'($urandom_range(0, 262143)) - 131072;
    for (int c = 0; c < NCOL; c++) x_mem[c] = int'($urandom_range(0, 262143)) - 131072;
  endtask

  task automatic run_one(input bit chk_lat);
    @(negedge clk);
    exp_q.push_back(model());
    exp_dr++;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk); #1;
      if (chk_lat) begin
        if (k == 1) begin
          check("busy_in_calc", busy, 1);
          check("col_first_step", col_address, 1);
        end
        if (k == LAT - 1) check("dr_not_early", data_ready, 0);
        if (k == LAT)     check("dr_latency", data_ready, 1);
        if (k == LAT + 1) check("dr_one_wide", data_ready, 0);
      end
    end
    check("dr_count", dr_count, exp_dr);
    check("idle_busy", busy, 0);
    check("idle_col", col_address, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    fill_const(0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_col", col_address, 0);
    check("rst_busy", busy, 0);
    check("rst_dr", data_ready, 0);
    check("rst_out", |output_vector, 0);
    @(negedge clk);
    reset = 1'b0;

    // Identity matrix against [1.0, 2.0, -0.5, 3.0].
    for (int r = 0; r < NROW; r++)
      for (int c = 0; c < NCOL; c++) w_mem[r][c] = (r == c) ? ONE : 0;
    x_mem[0] = ONE; x_mem[1] = 2 * ONE; x_mem[2] = -ONE / 2; x_mem[3] = 3 * ONE;
    run_one(1'b1);
    check("ident_row0", $signed(output_vector[0*BW +: BW]), 2048);
    check("ident_row2", $signed(output_vector[2*BW +: BW]), -1024);

    // Large values: clamps or wraps depending on build.
    fill_const(31 * ONE, 31 * ONE);
    run_one(1'b0);

    // Negative weights, positive half: floor shift and sign extension.
    fill_const(-ONE, ONE / 2);
    run_one(1'b0);
    check("neg_row3", $signed(output_vector[3*BW +: BW]), -4096);

    // Random full-range operands.
    for (int t = 0; t < 3; t++) begin
      fill_rand();
      run_one(t == 0);
    end

    // Start pulses during CALC are ignored.
    fill_rand();
    @(negedge clk);
    exp_q.push_back(model());
    exp_dr++;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("pulse_dr_count", dr_count, exp_dr);
    check("pulse_idle", busy, 0);

    // Start held high: back-to-back runs, accumulators cleared each time.
    fill_rand();
    @(negedge clk);
    exp_q.push_back(model());
    exp_q.push_back(model());
    exp_dr += 2;
    start = 1'b1;
    @(posedge clk);
    repeat (12) @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("held_dr_count", dr_count, exp_dr);
    check("held_gap", last_stamp - prev_stamp, NCOL * P + 2);
    check("held_idle", busy, 0);

    // Reset sampled in the third CALC cycle aborts cleanly.
    fill_rand();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_col", col_address, 0);
    check("abort_out", |output_vector, 0);
    check("abort_dr", data_ready, 0);
    reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("abort_no_dr", dr_count, exp_dr);
    run_one(1'b1);

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
